// File: rtl/vga_font_rom_arbiter_pkg.sv
// Shared definitions for the font ROM arbiter: ROM geometry and the
// owner tag that travels down the read pipeline with every granted access.
package vga_font_rom_arbiter_pkg;

    localparam int ROM_ADDR_W = 12;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/vga_font_rom_arbiter.sv
// Font ROM arbiter: one read per clock, VGA has strict priority, the CPU has at
// most one read outstanding. Every grant is tagged with its owner and the
// returned byte is routed to that owner exactly two cycles after the grant.
module vga_font_rom_arbiter
    import vga_font_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ROM_ADDR_W,
    parameter int DATA_W   = ROM_DATA_W,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic              vga_valid_o,
    output logic [DATA_W-1:0] vga_data_o,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_starve_o,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_dout_i
);

    localparam int              CNT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    owner_e           grant;
    owner_e           tag1;
    logic             cpu_busy;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_nxt;

    // Grant mux: VGA first, then an idle CPU; the ROM stays quiet otherwise and
    // while reset is held, so no output is driven during reset.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        grant      = OWN_NONE;
        rom_en_o   = 1'b0;
        rom_addr_o = '0;
        if (rst_n_i) begin
            if (vga_req_i) begin
                grant      = OWN_VGA;
                rom_en_o   = 1'b1;
                rom_addr_o = vga_addr_i;
            end else if (cpu_req_i && !cpu_busy) begin
                grant      = OWN_CPU;
                rom_en_o   = 1'b1;
                rom_addr_o = cpu_addr_i;
            end
        end
    end

    // Next wait count: cleared by a CPU grant or a withdrawn request, counts up
    // (saturating) only for cycles the idle CPU loses to VGA.
    always_comb begin
        wait_nxt = wait_cnt;
        if (grant == OWN_CPU || !cpu_req_i) begin
            wait_nxt = '0;
        end else if (!cpu_busy && vga_req_i && wait_cnt != CNT_MAX) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    // Tag pipe and data capture: the byte on rom_dout_i belongs to whoever was
    // granted last cycle; the other owner's data register keeps its value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag1        <= OWN_NONE;
            vga_valid_o <= 1'b0;
            vga_data_o  <= '0;
            cpu_ack_o   <= 1'b0;
            cpu_data_o  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples the
            // pre-edge value of tag1, giving a true one-stage pipe.
            tag1        <= grant;
            vga_valid_o <= (tag1 == OWN_VGA);
            cpu_ack_o   <= (tag1 == OWN_CPU);
            if (tag1 == OWN_VGA) vga_data_o <= rom_dout_i;
            if (tag1 == OWN_CPU) cpu_data_o <= rom_dout_i;
        end
    end

    // CPU outstanding flag: set on grant, cleared at the edge ending the ack
    // cycle, so the earliest regrant is the cycle after the ack.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpu_busy <= 1'b0;
        end else if (grant == OWN_CPU) begin
            cpu_busy <= 1'b1;
        end else if (cpu_ack_o) begin
            cpu_busy <= 1'b0;
        end
    end

    // Starvation tracking: sticky flag raised when the wait count reaches
    // WAIT_MAX, dropped only when the CPU finally wins a grant.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt     <= '0;
            cpu_starve_o <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (grant == OWN_CPU) begin
                cpu_starve_o <= 1'b0;
            end else if (wait_nxt == CNT_MAX) begin
                cpu_starve_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_font_rom_arbiter.sv
// Bench for the font ROM arbiter: a ROM model, directed scenarios with
// hand-computed expectations, and a randomized phase, all watched by a
// cycle-level behavioural model of the arbitration rules.
module tb_vga_font_rom_arbiter;

    localparam int TB_WAIT_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        vga_req;
    logic [11:0] vga_addr;
    logic        vga_valid;
    logic [7:0]  vga_data;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic        cpu_ack;
    logic [7:0]  cpu_data;
    logic        cpu_starve;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [7:0]  rom_dout;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] rom [4096];

    vga_font_rom_arbiter #(
        .ADDR_W   (12),
        .DATA_W   (8),
        .WAIT_MAX (TB_WAIT_MAX)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .vga_req_i    (vga_req),
        .vga_addr_i   (vga_addr),
        .vga_valid_o  (vga_valid),
        .vga_data_o   (vga_data),
        .cpu_req_i    (cpu_req),
        .cpu_addr_i   (cpu_addr),
        .cpu_ack_o    (cpu_ack),
        .cpu_data_o   (cpu_data),
        .cpu_starve_o (cpu_starve),
        .rom_en_o     (rom_en),
        .rom_addr_o   (rom_addr),
        .rom_dout_i   (rom_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous font ROM: data appears the cycle after an enabled edge.
    always @(posedge clk) begin
        if (rom_en) rom_dout <= rom[rom_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: scheduled deliveries per owner, the cycle from
    // which the CPU may be granted again, and the starvation bookkeeping.
    // ------------------------------------------------------------------
    typedef struct {
        int         due;
        logic [7:0] data;
    } ev_t;

    initial begin
        ev_t        vga_q[$];
        ev_t        cpu_q[$];
        ev_t        ev;
        int         cpu_free;
        int         wait_n;
        logic       m_starve;
        logic [7:0] m_vdata;
        logic [7:0] m_cdata;
        logic       e_vv;
        logic       e_ca;
        logic       g_vga;
        logic       g_cpu;
        cpu_free = 0; wait_n = 0; m_starve = 0; m_vdata = 0; m_cdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vga_q.delete(); cpu_q.delete();
                cpu_free = 0; wait_n = 0; m_starve = 0; m_vdata = 0; m_cdata = 0;
                check("rst_rom_en",    32'(rom_en),     0);
                check("rst_vga_valid", 32'(vga_valid),  0);
                check("rst_vga_data",  32'(vga_data),   0);
                check("rst_cpu_ack",   32'(cpu_ack),    0);
                check("rst_cpu_data",  32'(cpu_data),   0);
                check("rst_starve",    32'(cpu_starve), 0);
            end else begin
                e_vv = (vga_q.size() > 0) && (vga_q[0].due == cyc);
                if (e_vv) begin ev = vga_q.pop_front(); m_vdata = ev.data; end
                e_ca = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
                if (e_ca) begin ev = cpu_q.pop_front(); m_cdata = ev.data; end

                g_vga = vga_req;
                g_cpu = !vga_req && cpu_req && (cyc >= cpu_free);

                check("m_rom_en",    32'(rom_en),     32'(g_vga || g_cpu));
                check("m_rom_addr",  32'(rom_addr),   g_vga ? 32'(vga_addr) : (g_cpu ? 32'(cpu_addr) : 0));
                check("m_vga_valid", 32'(vga_valid),  32'(e_vv));
                check("m_vga_data",  32'(vga_data),   32'(m_vdata));
                check("m_cpu_ack",   32'(cpu_ack),    32'(e_ca));
                check("m_cpu_data",  32'(cpu_data),   32'(m_cdata));
                check("m_starve",    32'(cpu_starve), 32'(m_starve));

                if (g_vga) vga_q.push_back('{due: cyc + 2, data: rom[vga_addr]});
                if (g_cpu) begin
                    cpu_q.push_back('{due: cyc + 2, data: rom[cpu_addr]});
                    cpu_free = cyc + 3;
                end
                if (g_cpu || !cpu_req) wait_n = 0;
                else if (cyc >= cpu_free && vga_req && wait_n < TB_WAIT_MAX) wait_n++;
                if (g_cpu) m_starve = 0;
                else if (wait_n == TB_WAIT_MAX) m_starve = 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic vr, input logic [11:0] va, input logic cr, input logic [11:0] ca);
        @(posedge clk); #1;
        vga_req = vr; vga_addr = va; cpu_req = cr; cpu_addr = ca;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'h012] = 8'hA5;
        rom[12'h013] = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            rom[12'h100 + i] = 8'h30 + 8'(i);
            rom[12'h140 + i] = 8'h40 + 8'(i);
        end
        rom_dout = 8'h00;
        rst_n = 1'b0; vga_req = 0; vga_addr = 0; cpu_req = 0; cpu_addr = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mid();
        check("reset_vga_valid", 32'(vga_valid), 0);
        check("reset_starve",    32'(cpu_starve), 0);

        // CPU-only reads of 0x012 then 0x013.
        drive(0, 0, 1, 12'h012); mid();
        check("cpu_grant_en",   32'(rom_en),   1);
        check("cpu_grant_addr", 32'(rom_addr), 32'h012);
        drive(0, 0, 1, 12'h012); mid();
        check("cpu_busy_no_en", 32'(rom_en),   0);
        drive(0, 0, 1, 12'h013); mid();
        check("cpu_ack_012",    32'(cpu_ack),  1);
        check("cpu_data_012",   32'(cpu_data), 32'hA5);
        check("no_grant_in_ack", 32'(rom_en),  0);
        drive(0, 0, 1, 12'h013); mid();
        check("cpu_regrant_en",   32'(rom_en),   1);
        check("cpu_regrant_addr", 32'(rom_addr), 32'h013);
        drive(0, 0, 1, 12'h013); mid();
        check("cpu_ack_wait", 32'(cpu_ack), 0);
        drive(0, 0, 0, 0); mid();
        check("cpu_ack_013",  32'(cpu_ack),  1);
        check("cpu_data_013", 32'(cpu_data), 32'h5A);
        drive(0, 0, 0, 0); mid();
        check("cpu_ack_single", 32'(cpu_ack), 0);

        // VGA burst 0x100..0x107.
        for (int k = 0; k < 11; k++) begin
            drive(k < 8, 12'h100 + 12'(k), 0, 0); mid();
            if (k >= 2 && k < 10) begin
                check("vga_burst_valid", 32'(vga_valid), 1);
                check("vga_burst_data",  32'(vga_data),  32'h30 + 32'(k - 2));
            end else begin
                check("vga_burst_idle",  32'(vga_valid), 0);
            end
        end

        // CPU 0x012 held across a 4-cycle VGA burst.
        for (int k = 0; k < 8; k++) begin
            drive(k < 4, 12'h140 + 12'(k), k < 6, 12'h012); mid();
            if (k == 4) check("cpu_after_burst_addr", 32'(rom_addr), 32'h012);
            if (k == 5) check("burst_last_vga_data",  32'(vga_data), 32'h43);
            if (k == 6) begin
                check("cpu_after_burst_ack",  32'(cpu_ack),  1);
                check("cpu_after_burst_data", 32'(cpu_data), 32'hA5);
            end
        end

        // Starvation: CPU held under 6 cycles of continuous VGA.
        for (int k = 0; k < 10; k++) begin
            drive(k < 6, 12'h100 + 12'(k), k < 8, 12'h012); mid();
            check("starve_flag", 32'(cpu_starve), 32'(k >= 4 && k <= 6));
            if (k == 6) check("starve_grant_addr", 32'(rom_addr), 32'h012);
            if (k == 8) check("starve_ack", 32'(cpu_ack), 1);
        end

        // Withdrawn CPU request while VGA busy.
        for (int k = 0; k < 8; k++) begin
            drive(k < 4, 12'h104, k < 2, 12'h013); mid();
            if (k >= 4) begin
                check("withdraw_no_en",  32'(rom_en),  0);
                check("withdraw_no_ack", 32'(cpu_ack), 0);
            end
        end
        check("withdraw_no_starve", 32'(cpu_starve), 0);

        // Reset with VGA reads in flight.
        for (int k = 0; k < 3; k++) drive(1, 12'h100 + 12'(k), 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_vga_valid", 32'(vga_valid), 0);
        check("midrst_vga_data",  32'(vga_data),  0);
        check("midrst_rom_en",    32'(rom_en),    0);
        check("midrst_rom_addr",  32'(rom_addr),  0);
        drive(0, 0, 0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            check("post_rst_no_valid", 32'(vga_valid), 0);
            drive(0, 0, 0, 0);
        end

        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge clk); #2;
                rst_n = 1'b0;
                drive(0, 0, 0, 0);
                @(posedge clk); #1 rst_n = 1'b1;
            end
            @(posedge clk); #1;
            vga_req  = ($urandom_range(0, 99) < 50);
            vga_addr = 12'($urandom);
            if ($urandom_range(0, 99) < 15) cpu_req = !cpu_req;
            if (!cpu_req) cpu_addr = 12'($urandom);
        end
        drive(0, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0);
        mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
